// File: rtl/fir_pkg.sv
// Shared FIR definitions: loader FSM states, default coefficient/tap geometry
// and the filter output width.
package fir_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_e;

  localparam int FIR_COEF_W   = 8;
  localparam int FIR_IDX_W    = 4;
  localparam int FIR_NUM_TAPS = 5;
  localparam int FIR_OUT_W    = 20;
endpackage

// File: rtl/fir_coef_loader.sv
// Streams NUM_TAPS coefficient bytes into the FIR coefficient bank, one indexed write per byte.
// Optional trailing checksum byte when FIR_COEF_CHECKSUM_EN is defined.
import fir_pkg::*;

module fir_coef_loader #(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int COEF_W   = FIR_COEF_W,
  parameter int IDX_W    = FIR_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [COEF_W-1:0] s_data,
  output logic              s_ready,
  output logic              coef_write_enable,
  output logic [IDX_W-1:0]  coef_number,
  output logic [COEF_W-1:0] coef_value,
  output logic              busy,
  output logic              done,
  output logic              chk_err
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TAPS - 1);

  fir_state_e       state;
  logic [IDX_W-1:0] idx;
  logic             hs;
  logic             go;

  assign s_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign busy    = s_ready;
  assign done    = (state == ST_DONE);
  assign hs      = s_valid && s_ready;
  assign go      = (state == ST_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      idx               <= '0;
      coef_write_enable <= 1'b0;
      coef_number       <= '0;
      coef_value        <= '0;
    end else begin
      coef_write_enable <= 1'b0;
      case (state)
        ST_IDLE: if (go) begin
          state <= ST_LOAD;
          idx   <= '0;
        end
        ST_LOAD: begin
          // a byte accepted alongside abort is still written
          if (hs) begin
            coef_write_enable <= 1'b1;
            coef_number       <= idx;
            coef_value        <= s_data;
            if (idx != LAST) idx <= idx + 1'b1;
          end
          if (abort) state <= ST_IDLE;
`ifdef FIR_COEF_CHECKSUM_EN
          else if (hs && idx == LAST) state <= ST_CHECK;
`else
          else if (hs && idx == LAST) state <= ST_DONE;
`endif
        end
`ifdef FIR_COEF_CHECKSUM_EN
        ST_CHECK: begin
          if (abort) state <= ST_IDLE;
          else if (hs) state <= ST_DONE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIR_COEF_CHECKSUM_EN
  logic [COEF_W-1:0] sum;
  logic              err;

  // sum wraps modulo 2**COEF_W; the check byte itself is never accumulated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      err <= 1'b0;
    end else if (go) begin
      sum <= '0;
      err <= 1'b0;
    end else if (hs && state == ST_LOAD) begin
      sum <= sum + s_data;
    end else if (hs && state == ST_CHECK && !abort && s_data != sum) begin
      err <= 1'b1;
    end
  end

  assign chk_err = err;
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized directed bench for fir_coef_loader; expected writes come from the byte list sent.
module tb_fir_coef_loader;
  localparam int NT = 5;
  localparam int CW = 8;
  localparam int IW = 4;
`ifdef FIR_COEF_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, abort, s_valid;
  logic [CW-1:0] s_data;
  logic          s_ready, coef_write_enable, busy, done, chk_err;
  logic [IW-1:0] coef_number;
  logic [CW-1:0] coef_value;

  fir_coef_loader #(.NUM_TAPS(NT), .COEF_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .coef_write_enable(coef_write_enable), .coef_number(coef_number),
    .coef_value(coef_value), .busy(busy), .done(done), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [CW-1:0] stim[$];
  logic [IW-1:0] obs_num[$];
  logic [CW-1:0] obs_val[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            done_cnt = 0;
  logic          done_we;
  logic [IW-1:0] done_num;
  logic [IW-1:0] m_num = '0;
  logic [CW-1:0] m_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // write/done recorder, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (coef_write_enable) begin
        obs_num.push_back(coef_number);
        obs_val.push_back(coef_value);
        obs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_we  = coef_write_enable;
        done_num = coef_number;
      end
    end
  end

  task automatic fill_random();
    stim = {};
    for (int i = 0; i < NT; i++) stim.push_back(CW'($urandom));
  endtask

  // trailing check byte (only consumed when the checksum feature is built in)
  task automatic add_sum(input bit good);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < NT; i++) s = s + stim[i];
    stim.push_back(good ? s : s + 1'b1);
  endtask

  task automatic clear_obs();
    obs_num = {}; obs_val = {}; obs_cyc = {}; done_cnt = 0;
  endtask

  // abort_mode: 0 none, 1 abort the cycle after the last byte, 2 abort with the last byte
  task automatic run_load(input bit gap, input int abort_mode, input int n_send);
    int k, guard;
    bit v;
    clear_obs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0; guard = 0;
    while (k < n_send && guard < 500) begin
      chk("s_ready_in_load", 32'(s_ready), 32'd1);
      v = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = v;
      s_data  = v ? stim[k] : CW'($urandom);
      if (gap) start = 1'($urandom_range(0, 1));
      abort = (abort_mode == 2) && v && (k == n_send - 1);
      @(negedge clk);
      if (v) begin
        if (k < NT) begin m_num = IW'(k); m_val = stim[k]; end
        chk("we_after_accept", 32'(coef_write_enable), 32'(k < NT));
        k++;
      end else begin
        chk("we_in_gap", 32'(coef_write_enable), 32'd0);
      end
      chk("num_held", 32'(coef_number), 32'(m_num));
      chk("val_held", 32'(coef_value), 32'(m_val));
      guard++;
    end
    chk("stream_timeout", 32'(k), 32'(n_send));
    s_valid = 1'b0; start = 1'b0;
    abort = (abort_mode == 1);
    @(negedge clk); abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("s_ready_after", 32'(s_ready), 32'd0);
  endtask

  task automatic verify(input int n_w, input int exp_done, input bit consecutive);
    chk("write_count", 32'(obs_num.size()), 32'(n_w));
    for (int i = 0; i < n_w && i < obs_num.size(); i++) begin
      chk("write_num", 32'(obs_num[i]), 32'(i));
      chk("write_val", 32'(obs_val[i]), 32'(stim[i]));
    end
    if (consecutive && obs_cyc.size() == n_w && n_w > 0)
      chk("write_burst", 32'(obs_cyc[n_w-1] - obs_cyc[0]), 32'(n_w - 1));
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    if (exp_done == 1 && done_cnt == 1) begin
      chk("done_with_strobe", 32'(done_we), 32'(CHK == 0));
      if (CHK == 0) chk("done_num", 32'(done_num), 32'(NT - 1));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(coef_write_enable), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_s_ready", 32'(s_ready), 32'd0);
      chk("idle_we", 32'(coef_write_enable), 32'd0);
      chk("idle_num", 32'(coef_number), 32'd0);
      chk("idle_val", 32'(coef_value), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_chk_err", 32'(chk_err), 32'd0);
    end

    // back-to-back directed stream, then the same stream gapped with stray starts
    stim = {8'd3, 8'd7, 8'd1, 8'd9, 8'd2}; add_sum(1'b1);
    run_load(1'b0, 0, NT + CHK); verify(NT, 1, 1'b1);
    run_load(1'b1, 0, NT + CHK); verify(NT, 1, 1'b0);
    chk("chk_err_clean", 32'(chk_err), 32'd0);

    for (int r = 0; r < 6; r++) begin
      fill_random(); add_sum(1'b1);
      run_load(1'(r % 2), 0, NT + CHK); verify(NT, 1, 1'(r % 2 == 0));
      chk("chk_err_rand", 32'(chk_err), 32'd0);
    end

    // abort after two bytes, then reload from tap 0
    stim = {8'd5, 8'd6};
    run_load(1'b0, 1, 2); verify(2, 0, 1'b1);
    fill_random(); add_sum(1'b1);
    run_load(1'b0, 0, NT + CHK); verify(NT, 1, 1'b1);

    // abort coincident with the third byte: that byte still lands
    fill_random();
    run_load(1'b1, 2, 3); verify(3, 0, 1'b0);

    // start+abort together in IDLE stays idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_abort_busy", 32'(busy), 32'd0);
      chk("start_abort_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end

    // reset while a write strobe is showing
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
    @(posedge clk); #1;
    chk("pre_reset_we", 32'(coef_write_enable), 32'd1);
    rst_n = 1'b0; #1;
    chk("reset_we", 32'(coef_write_enable), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_val", 32'(coef_value), 32'd0);
    s_valid = 1'b0; m_num = '0; m_val = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(s_ready), 32'd0);

`ifdef FIR_COEF_CHECKSUM_EN
    stim = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd15};
    run_load(1'b0, 0, NT + 1); verify(NT, 1, 1'b1);
    chk("chk_good", 32'(chk_err), 32'd0);
    stim[NT] = 8'd16;
    run_load(1'b1, 0, NT + 1); verify(NT, 1, 1'b0);
    chk("chk_bad", 32'(chk_err), 32'd1);
    repeat (4) @(negedge clk);
    chk("chk_bad_held", 32'(chk_err), 32'd1);
    fill_random(); add_sum(1'b0);
    run_load(1'b0, 0, NT + 1); verify(NT, 1, 1'b1);
    chk("chk_bad_rand", 32'(chk_err), 32'd1);
    fill_random(); add_sum(1'b1);
    run_load(1'b1, 0, NT + 1); verify(NT, 1, 1'b0);
    chk("chk_cleared", 32'(chk_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
